dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the RV64 core: the memory-side end of the load/store request channel that the CPU's MEM stage initiates. It accepts one request at a time over a valid/ready handshake. It performs sized, lane-aligned reads and writes on an internal array of 64-bit dwords. After a fixed configurable latency it returns extended load data, or an error for misaligned or out-of-range accesses.

## Interface
- DEPTH, 64: number of 64-bit dwords in the array; valid byte addresses are 0 .. 8*DEPTH-1.
- LATENCY, 2: cycles from request acceptance to response; must be ≥1.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_op  in  mem_op_e  MEM_LOAD or MEM_STORE.
- req_size  in  2  0=byte, 1=half, 2=word, 3=dword.
- req_ext  in  size_ext_e  load extension (SizeExtSigned or SizeExtZero); ignored for stores and for size 3.
- req_addr  in  64  byte address.
- req_wdata  in  64  store data, right-aligned (LSBs hold the datum).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  initiator accepts the response.
- rsp_rdata  out  64  load result, extended to 64 bits; 0 for stores and errors.
- rsp_err  out  1  access was misaligned or out of range.
- st_err  out  1  sticky flag for a dropped store error; used only when store acks are disabled.

## Operation
- FSM states (dmem_state_e): IDLE, WAIT, RESP.
- IDLE: req_ready=1. When req_valid=1, the request is latched (op, size, ext, addr, wdata). If LATENCY==1 the next state is RESP; otherwise it is WAIT, with the counter loaded to LATENCY-2.
- WAIT: the counter decrements each cycle. At 0, the access is performed and the next state is RESP.
- The access is performed on the edge that enters RESP:
  - error = (addr mod 2^size ≠ 0) or (addr>>3 ≥ DEPTH);
  - on error: no array write, rsp_rdata=0, rsp_err=1;
  - load: the dword at index addr>>3 is shifted right by 8*addr[2:0], masked to the size, then sign- or zero-extended per req_ext;
  - store: only the byte lanes addr[2:0] .. addr[2:0]+2^size-1 are written with the low bytes of wdata; all other lanes are preserved.
- RESP: rsp_valid=1, and the outputs hold stable until rsp_ready=1, after which the next state is IDLE.
- Only one request is outstanding at a time. req_ready=0 in WAIT and RESP, so no request is accepted on the cycle a response retires.
- A store followed by a load to the same address returns the stored data (strict ordering).

## Timing
- Reset values: FSM in IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, st_err=0, counter=0. Array contents are not reset.
- rsp_valid rises exactly LATENCY cycles after the acceptance edge.
- Maximum throughput is one request per LATENCY+1 cycles when rsp_ready is held high.
- Reset mid-operation returns the FSM to IDLE and abandons the pending request. A store that has not yet reached its perform edge is not written.
- The array is written only on the perform edge; a held response never rewrites it.
- All outputs are registered. None depends combinationally on req_* or rsp_ready.

## Configuration
- DMEM_STORE_ACK_EN defined: stores produce a response like loads (rsp_rdata=0, rsp_err per the error rule), and st_err stays 0.
- DMEM_STORE_ACK_EN undefined:
  - stores skip RESP and go from the perform edge directly to IDLE, with no rsp_valid pulse;
  - an erroring store is dropped and sets st_err=1, which stays set until reset;
  - a store therefore occupies LATENCY cycles.

## Structure
- The shared package holds:
  - dmem_state_e;
  - the existing mem_op_e (MEM_LOAD, MEM_STORE) and size_ext_e;
  - a constant DMEM_BYTES_PER_WORD=8.
- Sub-module dmem_lane_align (combinational):
  - inputs: dword, offset, size, ext, wdata;
  - outputs: extended load value, merged store dword, misalign flag.
- The top level holds the FSM, the counter, the request register and the array.

## Test plan
- Store then load: store dword 0x1122334455667788 at addr 0x10, then load size 3 from 0x10 → rsp_rdata=0x1122334455667788, rsp_err=0, with rsp_valid exactly 2 cycles after acceptance.
- Byte lane and extension: store byte 0x80 at addr 0x13.
  - Load byte signed from 0x13 → 0xFFFFFFFFFFFFFF80.
  - Load byte zero-extended → 0x80.
  - Load dword from 0x10 → only byte 3 has changed.
- Misaligned access: load word from 0x22 → rsp_err=1, rsp_rdata=0. A store half to 0x21 → rsp_err=1 and the array is unchanged, confirmed by a readback.
- Out of range with DEPTH=64: load from 0x200 → rsp_err=1. Load from 0x1F8 → rsp_err=0.
- Backpressure: hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_rdata stay stable and req_ready stays 0. With rsp_ready=1, the FSM is IDLE next cycle and req_ready=1.
- Reset mid-store, with DMEM_STORE_ACK_EN undefined and LATENCY=3: accept a store to 0x08, then assert rst one cycle later → req_ready=1 and rsp_valid=0 after reset, and a subsequent load from 0x08 returns the old value. A misaligned store sets st_err=1 with no rsp_valid pulse.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_responder_pkg;

    localparam int unsigned DMEM_BYTES_PER_WORD = 8;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } dmem_state_e;

    typedef enum logic {
        MEM_LOAD,
        MEM_STORE
    } mem_op_e;

    typedef enum logic {
        SizeExtSigned,
        SizeExtZero
    } size_ext_e;

    // Byte-lane mask of an access of 2^size bytes starting at lane 0.
    function automatic logic [7:0] size_byte_mask(input logic [1:0] size);
        logic [7:0] mask;
        unique case (size)
            2'd0:    mask = 8'h01;
            2'd1:    mask = 8'h03;
            2'd2:    mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane alignment: load extraction/extension, store merge and
// natural-alignment check for one 64-bit dword.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [63:0] i_dword,
    input  logic [2:0]  i_offset,
    input  logic [1:0]  i_size,
    input  size_ext_e   i_ext,
    input  logic [63:0] i_wdata,
    output logic [63:0] o_load,
    output logic [63:0] o_store,
    output logic        o_misalign
);

    logic [5:0]  w_shamt;
    logic [63:0] w_shifted;
    logic [7:0]  w_lanes;
    logic [63:0] w_bitmask;
    logic        w_signed;

    assign w_shamt   = {i_offset, 3'b000};
    assign w_shifted = i_dword >> w_shamt;
    assign w_signed  = (i_ext == SizeExtSigned);

    // Expand the active byte lanes into a bit mask for the store merge.
    always_comb begin
        w_lanes   = size_byte_mask(i_size) << i_offset;
        w_bitmask = '0;
        for (int i = 0; i < DMEM_BYTES_PER_WORD; i++) begin
            w_bitmask[8*i +: 8] = {8{w_lanes[i]}};
        end
    end

    // Load value: right-aligned datum, sign- or zero-extended by size.
    always_comb begin
        o_load = '0;
        unique case (i_size)
            2'd0: o_load = {{56{w_signed & w_shifted[7]}},  w_shifted[7:0]};
            2'd1: o_load = {{48{w_signed & w_shifted[15]}}, w_shifted[15:0]};
            2'd2: o_load = {{32{w_signed & w_shifted[31]}}, w_shifted[31:0]};
            default: o_load = w_shifted;
        endcase
    end

    // Misalignment: offset must be a multiple of the access size.
    always_comb begin
        o_misalign = 1'b0;
        unique case (i_size)
            2'd0: o_misalign = 1'b0;
            2'd1: o_misalign = i_offset[0];
            2'd2: o_misalign = |i_offset[1:0];
            default: o_misalign = |i_offset;
        endcase
    end

    assign o_store = (i_dword & ~w_bitmask) | ((i_wdata << w_shamt) & w_bitmask);

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed latency, sized
// lane-aligned access to a dword array.
// Build option: DMEM_STORE_ACK_EN -- when defined, stores return a response
// like loads; otherwise stores retire silently and erroring stores set st_err.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  mem_op_e     i_req_op,
    input  logic [1:0]  i_req_size,
    input  size_ext_e   i_req_ext,
    input  logic [63:0] i_req_addr,
    input  logic [63:0] i_req_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [63:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_st_err
);

`ifdef DMEM_STORE_ACK_EN
    localparam bit StoreAck = 1'b1;
`else
    localparam bit StoreAck = 1'b0;
`endif

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'((LATENCY >= 2) ? (LATENCY - 2) : 0);
    localparam bit Lat1 = (LATENCY == 1);

    dmem_state_e r_state, w_state_d;
    logic [CntW-1:0] r_cnt, w_cnt_d;
    logic [63:0]     r_rdata, w_rdata_d;
    logic            r_err, w_err_d;
    logic            r_st_err, w_st_err_d;

    mem_op_e     r_op;
    logic [1:0]  r_size;
    size_ext_e   r_ext;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;

    logic [63:0] r_mem [DEPTH];

    logic            w_accept;
    logic            w_perform;
    logic            w_use_in;
    mem_op_e         w_acc_op;
    logic [1:0]      w_acc_size;
    size_ext_e       w_acc_ext;
    logic [63:0]     w_acc_addr;
    logic [63:0]     w_acc_wdata;
    logic [IdxW-1:0] w_idx;
    logic            w_oor;
    logic            w_misalign;
    logic            w_err;
    logic            w_mem_we;
    logic [63:0]     w_load;
    logic [63:0]     w_store;

    // With LATENCY==1 the access is performed on the acceptance edge, so it
    // must see the incoming request rather than the latched copy.
    assign w_use_in    = Lat1 && (r_state == StIdle);
    assign w_acc_op    = w_use_in ? i_req_op    : r_op;
    assign w_acc_size  = w_use_in ? i_req_size  : r_size;
    assign w_acc_ext   = w_use_in ? i_req_ext   : r_ext;
    assign w_acc_addr  = w_use_in ? i_req_addr  : r_addr;
    assign w_acc_wdata = w_use_in ? i_req_wdata : r_wdata;

    assign w_idx    = w_acc_addr[IdxW+2:3];
    assign w_oor    = (w_acc_addr[63:3] >= 61'(DEPTH));
    assign w_err    = w_oor | w_misalign;
    assign w_mem_we = w_perform && (w_acc_op == MEM_STORE) && !w_err;

    dmem_lane_align u_lane_align (
        .i_dword    (r_mem[w_idx]),
        .i_offset   (w_acc_addr[2:0]),
        .i_size     (w_acc_size),
        .i_ext      (w_acc_ext),
        .i_wdata    (w_acc_wdata),
        .o_load     (w_load),
        .o_store    (w_store),
        .o_misalign (w_misalign)
    );

    // Next-state, counter and response computation.
    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt;
        w_rdata_d  = r_rdata;
        w_err_d    = r_err;
        w_st_err_d = r_st_err;
        w_accept   = 1'b0;
        w_perform  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_req_valid) begin
                    w_accept = 1'b1;
                    if (Lat1) begin
                        w_perform = 1'b1;
                    end else begin
                        w_state_d = StWait;
                        w_cnt_d   = CntLoad;
                    end
                end
            end
            StWait: begin
                if (r_cnt == '0) begin
                    w_perform = 1'b1;
                end else begin
                    w_cnt_d = r_cnt - CntW'(1);
                end
            end
            StResp: begin
                if (i_rsp_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
        if (w_perform) begin
            if ((w_acc_op == MEM_LOAD) || StoreAck) begin
                w_state_d = StResp;
                w_rdata_d = ((w_acc_op == MEM_LOAD) && !w_err) ? w_load : '0;
                w_err_d   = w_err;
            end else begin
                // Unacknowledged store retires straight to idle.
                w_state_d = StIdle;
                if (w_err) begin
                    w_st_err_d = 1'b1;
                end
            end
        end
    end

    // FSM, counter and registered response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_st_err <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_rdata  <= w_rdata_d;
            r_err    <= w_err_d;
            r_st_err <= w_st_err_d;
        end
    end

    // Request register, captured on acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op    <= MEM_LOAD;
            r_size  <= '0;
            r_ext   <= SizeExtSigned;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_op    <= i_req_op;
            r_size  <= i_req_size;
            r_ext   <= i_req_ext;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
        end
    end

    // Array write on the perform edge only; contents are not reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= w_store;
        end
    end

    assign o_req_ready = (r_state == StIdle);
    assign o_rsp_valid = (r_state == StResp);
    assign o_rsp_rdata = r_rdata;
    assign o_rsp_err   = r_err;
    assign o_st_err    = r_st_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: byte-array reference model, directed
// cases followed by randomized traffic with random response backpressure.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned LAT   = 2;
`ifdef DMEM_STORE_ACK_EN
    localparam bit StoreAck = 1'b1;
`else
    localparam bit StoreAck = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    mem_op_e     req_op = MEM_LOAD;
    logic [1:0]  req_size = '0;
    size_ext_e   req_ext = SizeExtZero;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic        st_err;

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_op    (req_op),
        .i_req_size  (req_size),
        .i_req_ext   (req_ext),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_rdata (rsp_rdata),
        .o_rsp_err   (rsp_err),
        .o_st_err    (st_err)
    );

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        sb_q[$];
    logic [7:0]  mem_m [8*DEPTH];
    bit          st_err_exp = 1'b0;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          rdy_mode = 0;
    logic [63:0] last_rdata = '0;
    logic        last_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model: byte-addressed memory, natural alignment, bounds.
    function automatic exp_t model(input mem_op_e op, input logic [1:0] size,
                                   input size_ext_e ext, input logic [63:0] addr,
                                   input logic [63:0] wdata);
        exp_t        e;
        int          n;
        logic [63:0] v;
        n       = 1 << size;
        e.err   = ((addr % 64'(n)) != 0) || (addr >= 64'(8 * DEPTH));
        e.rdata = '0;
        e.acc   = 0;
        if (!e.err) begin
            if (op == MEM_LOAD) begin
                v = '0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = mem_m[int'(addr[9:0]) + i];
                if (ext == SizeExtSigned && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
                e.rdata = v;
            end else begin
                for (int i = 0; i < n; i++) mem_m[int'(addr[9:0]) + i] = wdata[8*i +: 8];
            end
        end else if (op == MEM_STORE && !StoreAck) begin
            st_err_exp = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [63:0] peek_dword(input int idx);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = mem_m[8*idx + i];
        return v;
    endfunction

    // Present one request and return just after its acceptance edge.
    task automatic issue(input mem_op_e op, input logic [1:0] size, input size_ext_e ext,
                         input logic [63:0] addr, input logic [63:0] wdata, input bit use_model);
        exp_t e;
        int   n;
        @(negedge clk);
        req_op    = op;
        req_size  = size;
        req_ext   = ext;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            tests++;
            fails++;
            $display("FAIL req_accept_timeout: req_ready stuck at %b, expected 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        if (use_model) begin
            e     = model(op, size, ext, addr, wdata);
            e.acc = cyc;
            if (op == MEM_LOAD || StoreAck) sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sb_q.size() == 0 && req_ready) && n < 300);
        if (!(sb_q.size() == 0 && req_ready)) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: pending=%0d req_ready=%b, expected 0 and 1",
                     sb_q.size(), req_ready);
        end
    endtask

    // Response-ready driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'b0;
                default: rsp_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: latency, hold stability and scoreboard comparison.
    initial begin
        logic        pv, pr, perr;
        logic [63:0] prd;
        exp_t        e;
        pv = 1'b0; pr = 1'b0; perr = 1'b0; prd = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pv = 1'b0;
                pr = 1'b0;
            end else begin
                if (rsp_valid && !pv) begin
                    if (sb_q.size() == 0) begin
                        check64("unexpected_rsp_valid", 64'(rsp_valid), 64'd0);
                    end else begin
                        check64("rsp_latency", 64'(cyc - sb_q[0].acc), 64'(LAT));
                    end
                end
                if (pv && !pr) begin
                    check64("hold_valid", 64'(rsp_valid), 64'd1);
                    check64("hold_rdata", rsp_rdata, prd);
                    check64("hold_err", 64'(rsp_err), 64'(perr));
                end
                if (rsp_valid && rsp_ready && sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check64("rsp_rdata", rsp_rdata, e.rdata);
                    check64("rsp_err", 64'(rsp_err), 64'(e.err));
                    last_rdata = rsp_rdata;
                    last_err   = rsp_err;
                end
                pv   = rsp_valid;
                pr   = rsp_ready;
                prd  = rsp_rdata;
                perr = rsp_err;
            end
        end
    end

    initial begin
        exp_t        e;
        logic [63:0] old8;
        int          n;
        mem_op_e     op;
        logic [1:0]  sz;
        size_ext_e   ex;
        logic [63:0] ad;
        int          r;

        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check64("reset_req_ready", 64'(req_ready), 64'd1);
        check64("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check64("reset_rsp_rdata", rsp_rdata, 64'd0);
        check64("reset_rsp_err", 64'(rsp_err), 64'd0);
        check64("reset_st_err", 64'(st_err), 64'd0);

        // Give every dword a known value.
        for (int i = 0; i < int'(DEPTH); i++) begin
            issue(MEM_STORE, 2'd3, SizeExtZero, 64'(8 * i), {$urandom, $urandom}, 1'b1);
        end
        wait_idle();

        issue(MEM_STORE, 2'd3, SizeExtZero, 64'h10, 64'h1122334455667788, 1'b1);
        issue(MEM_LOAD, 2'd3, SizeExtZero, 64'h10, '0, 1'b1);
        wait_idle();
        check64("store_load_dword", last_rdata, 64'h1122334455667788);
        check64("store_load_err", 64'(last_err), 64'd0);

        issue(MEM_STORE, 2'd0, SizeExtZero, 64'h13, 64'h80, 1'b1);
        issue(MEM_LOAD, 2'd0, SizeExtSigned, 64'h13, '0, 1'b1);
        wait_idle();
        check64("byte_signed", last_rdata, 64'hFFFFFFFFFFFFFF80);
        issue(MEM_LOAD, 2'd0, SizeExtZero, 64'h13, '0, 1'b1);
        wait_idle();
        check64("byte_zero", last_rdata, 64'h80);
        issue(MEM_LOAD, 2'd3, SizeExtZero, 64'h10, '0, 1'b1);
        wait_idle();
        check64("byte_lane_merge", last_rdata, 64'h1122334480667788);

        issue(MEM_LOAD, 2'd2, SizeExtZero, 64'h22, '0, 1'b1);
        wait_idle();
        check64("misalign_load_err", 64'(last_err), 64'd1);
        check64("misalign_load_rdata", last_rdata, 64'd0);
        issue(MEM_STORE, 2'd1, SizeExtZero, 64'h21, 64'hFFFF, 1'b1);
        wait_idle();
        check64("misalign_store_st_err", 64'(st_err), 64'(st_err_exp));
        issue(MEM_LOAD, 2'd3, SizeExtZero, 64'h20, '0, 1'b1);
        wait_idle();
        check64("misalign_store_readback", last_rdata, peek_dword(4));

        issue(MEM_LOAD, 2'd3, SizeExtZero, 64'h200, '0, 1'b1);
        wait_idle();
        check64("oor_err", 64'(last_err), 64'd1);
        issue(MEM_LOAD, 2'd3, SizeExtZero, 64'h1F8, '0, 1'b1);
        wait_idle();
        check64("last_dword_err", 64'(last_err), 64'd0);

        // Backpressure: hold the response for five cycles.
        rdy_mode = 1;
        issue(MEM_LOAD, 2'd3, SizeExtZero, 64'h10, '0, 1'b1);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check64("bp_rsp_valid_seen", 64'(rsp_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check64("bp_valid", 64'(rsp_valid), 64'd1);
            check64("bp_rdata", rsp_rdata, 64'h1122334480667788);
            check64("bp_req_ready", 64'(req_ready), 64'd0);
        end
        rdy_mode = 0;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        check64("bp_release_req_ready", 64'(req_ready), 64'd1);
        check64("bp_release_rsp_valid", 64'(rsp_valid), 64'd0);

        // Reset before the store reaches its perform edge.
        old8 = peek_dword(1);
        issue(MEM_STORE, 2'd3, SizeExtZero, 64'h08, 64'hDEADBEEFCAFEF00D, 1'b0);
        rst = 1'b0;
        sb_q.delete();
        st_err_exp = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check64("midrst_req_ready", 64'(req_ready), 64'd1);
        check64("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        check64("midrst_st_err", 64'(st_err), 64'd0);
        issue(MEM_LOAD, 2'd3, SizeExtZero, 64'h08, '0, 1'b1);
        wait_idle();
        check64("midrst_old_value", last_rdata, old8);

        issue(MEM_STORE, 2'd1, SizeExtZero, 64'h21, 64'h1234, 1'b1);
        wait_idle();
        check64("st_err_sticky", 64'(st_err), 64'(st_err_exp));

        // Randomized traffic with random response backpressure.
        rdy_mode = 2;
        for (int k = 0; k < 300; k++) begin
            op = ($urandom_range(0, 1) == 0) ? MEM_LOAD : MEM_STORE;
            sz = 2'($urandom_range(0, 3));
            ex = ($urandom_range(0, 1) == 0) ? SizeExtSigned : SizeExtZero;
            r  = $urandom_range(0, 9);
            ad = 64'($urandom_range(0, 8 * DEPTH - 1));
            if (r < 7)       ad = ad & ~((64'd1 << sz) - 64'd1);
            else if (r == 8) ad = 64'(8 * DEPTH) + 64'($urandom_range(0, 1023));
            else if (r == 9) ad = {$urandom, $urandom};
            issue(op, sz, ex, ad, {$urandom, $urandom}, 1'b1);
        end
        wait_idle();
        rdy_mode = 0;
        check64("final_queue_empty", 64'(sb_q.size()), 64'd0);
        check64("final_st_err", 64'(st_err), 64'(st_err_exp));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
